// File: rtl/qdiv_seq.sv
// Sequential sign-magnitude Q-format divider: one restoring step per clock, start/done handshake.
// Optional feature macro QDIV_ROUND_EN: one extra quotient bit, round half away from zero.
module qdiv_seq #(
  parameter int N = 32,
  parameter int Q = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic         done,
  output logic         busy,
  output logic         overflow,
  output logic         div_by_zero
);

`ifdef QDIV_ROUND_EN
  localparam int QW = N + Q;
`else
  localparam int QW = N - 1 + Q;
`endif
  localparam int TW = N - 1 + Q;
  localparam int CW = $clog2(QW + 1);
  localparam logic [CW-1:0] LAST = CW'(QW - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [QW-1:0] dq_q, dq_d;
  logic [N-2:0]  rem_q, rem_d;
  logic [N-2:0]  dvs_q, dvs_d;
  logic          sign_q, sign_d;
  logic          dz_q, dz_d;
  logic [N-1:0]  quot_q, quot_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic          dbz_q, dbz_d;

  // Dividend bits shift out of the top of dq while quotient bits shift in at the bottom.
  logic [N-1:0]  shifted;
  logic [N-2:0]  diff;
  logic          noBorrow;
  logic [TW-1:0] qTrunc;
  logic          roundBit;
  logic [N-1:0]  magSum;
  logic          sat;
  logic [N-2:0]  resMag;

  assign shifted  = {rem_q, dq_q[QW-1]};
  assign noBorrow = (shifted >= {1'b0, dvs_q});
  assign diff     = shifted[N-2:0] - dvs_q;

`ifdef QDIV_ROUND_EN
  assign qTrunc   = dq_q[QW-1:1];
  assign roundBit = dq_q[0];
`else
  assign qTrunc   = dq_q;
  assign roundBit = 1'b0;
`endif

  assign magSum = {1'b0, qTrunc[N-2:0]} + {{(N-1){1'b0}}, roundBit};
  assign sat    = (|qTrunc[TW-1:N-1]) | magSum[N-1];
  assign resMag = sat ? {(N-1){1'b1}} : magSum[N-2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dq_q    <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      sign_q  <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dq_q    <= dq_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      sign_q  <= sign_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dq_d    = dq_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    sign_d  = sign_q;
    dz_d    = dz_q;
    quot_d  = quot_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          dvs_d  = divisor[N-2:0];
          dq_d   = {dividend[N-2:0], {(QW-N+1){1'b0}}};
          rem_d  = '0;
          sign_d = dividend[N-1] ^ divisor[N-1];
          cnt_d  = '0;
          if (divisor[N-2:0] == '0) begin
            // The extra wait cycle in FIN gives divide-by-zero a latency of 2.
            state_d = FIN;
            cnt_d   = CW'(1);
            dz_d    = 1'b1;
          end else begin
            state_d = CALC;
            dz_d    = 1'b0;
          end
        end
      end
      CALC: begin
        dq_d  = {dq_q[QW-2:0], noBorrow};
        rem_d = noBorrow ? diff : shifted[N-2:0];
        if (cnt_q == LAST) begin
          state_d = FIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FIN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
          if (dz_q) begin
            quot_d = {sign_q, {(N-1){1'b1}}};
            ovf_d  = 1'b0;
            dbz_d  = 1'b1;
          end else begin
            quot_d = {sign_q & (|resMag), resMag};
            ovf_d  = sat;
            dbz_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign quotient    = quot_q;
  assign done        = done_q;
  assign busy        = (state_q != IDLE);
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;

endmodule
